ksa_wb_bist_master: RTL

Wishbone classic initiator that drives the 16-bit Kogge-Stone adder's Wishbone responder as a built-in self-test. On start it generates NUM_VECTORS pseudo-random operand sets from an LFSR and, for each set, writes the operands and carry-in, reads back the result, and compares it against a locally computed sum. Error and vector counters, a first-failure snapshot and pass/timeout flags go to logic-analyzer probes for the management SoC.

---
 rtl/ksa_bist_pkg.sv | 23 ++
 rtl/ksa_wb_bist_master_lfsr32.sv | 23 ++
 rtl/ksa_wb_bist_master.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ksa_bist_pkg.sv
// Shared types and constants for the Kogge-Stone adder Wishbone BIST master.
package ksa_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_OP,
        WR_CIN,
        RD_RES,
        CHECK,
        DONE
    } state_t;

    localparam logic [31:0] OPERAND_OFS = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFS    = 32'h0000_0004;
    localparam logic [31:0] RESULT_OFS  = 32'h0000_0008;
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/ksa_wb_bist_master_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enables.
module lfsr32
    import ksa_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/ksa_wb_bist_master.sv
// Wishbone classic initiator that self-tests the Kogge-Stone adder responder.
module ksa_wb_bist_master
    import ksa_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] SEED        = 32'h0001_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_count_o,
    output logic [15:0] vec_count_o,
    output logic [32:0] fail_vec_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [15:0] NV = 16'(NUM_VECTORS);
    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t      state;
    logic [15:0] tcnt;
    logic [16:0] res;
    logic [31:0] q;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] expected;
    logic        mismatch;
    logic        unused_dat;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign a          = q[15:0];
    assign b          = q[31:16];
    assign cin        = vec_count_o[0];
    assign expected   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    assign mismatch   = (res != expected);
    assign unused_dat = ^wbm_dat_i[31:17];

    lfsr32 u_lfsr (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .load  (state == IDLE && start_i),
        .seed  (SEED),
        .step  (state == CHECK),
        .q     (q)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            err_count_o <= '0;
            vec_count_o <= '0;
            fail_vec_o  <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            tcnt        <= '0;
            res         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        timeout_o   <= 1'b0;
                        err_count_o <= '0;
                        vec_count_o <= '0;
                        fail_vec_o  <= '0;
                        // LFSR loads on this same edge, so the first operands are SEED itself.
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= 1'b1;
                        wbm_sel_o   <= 4'hF;
                        wbm_adr_o   <= BASE_ADDR + OPERAND_OFS;
                        wbm_dat_o   <= SEED;
                        tcnt        <= '0;
                        state       <= WR_OP;
                    end
                end
                WR_OP, WR_CIN, RD_RES: begin
                    if (wbm_stb_o) begin
                        if (wbm_ack_i) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= '0;
                            if (state == RD_RES) begin
                                res   <= wbm_dat_i[16:0];
                                state <= CHECK;
                            end
                        end else if (tcnt == TO - 16'd1) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= '0;
                            timeout_o <= 1'b1;
                            done_o    <= 1'b1;
                            busy_o    <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end else begin
                        // Idle bus cycle after a write ack; launch the next transfer.
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        tcnt      <= '0;
                        if (state == WR_OP) begin
                            wbm_we_o  <= 1'b1;
                            wbm_adr_o <= BASE_ADDR + CTRL_OFS;
                            wbm_dat_o <= {31'b0, cin};
                            state     <= WR_CIN;
                        end else begin
                            wbm_we_o  <= 1'b0;
                            wbm_adr_o <= BASE_ADDR + RESULT_OFS;
                            wbm_dat_o <= '0;
                            state     <= RD_RES;
                        end
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count_o <= sat_inc(err_count_o);
                        if (err_count_o == 16'd0) begin
                            fail_vec_o <= {cin, b, a};
                        end
                    end
                    vec_count_o <= vec_count_o + 16'd1;
                    if (vec_count_o + 16'd1 == NV) begin
                        done_o <= 1'b1;
                        pass_o <= (err_count_o == 16'd0) && !mismatch;
                        state  <= DONE;
                    end else begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        wbm_adr_o <= BASE_ADDR + OPERAND_OFS;
                        wbm_dat_o <= lfsr_next(q);
                        tcnt      <= '0;
                        state     <= WR_OP;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
